ca_rng_scheduler: RTL and testbench
===================================

Name: ca_rng_scheduler

Overview:
Owns an 8-bit hybrid rule-90/150 cellular-automaton generator and shares it among NUM_REQ requesters with round-robin arbitration. Each grant delivers one 8-bit value and advances the CA one step. The block also sequences seeding: it loads the seed, rejects the all-zero seed, and runs a warm-up before serving. It sits between the CA datapath and the blocks that need pseudo-random bytes, such as test-pattern and scrambler consumers.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WARMUP, 4, CA steps executed after reset or seed load before serving (0..255; 0 = serve immediately)
DEFAULT_SEED, 8'h01, CA state loaded at reset (must be nonzero)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
seed_load  in  1  pulse; load seed_value and restart warm-up
seed_value  in  8  seed to load
gen_enable  in  1  1 = grants allowed in SERVE
req  in  NUM_REQ  per-requester request, level, sampled every cycle
gnt  out  NUM_REQ  registered one-hot grant, one cycle wide
rnd_valid  out  1  high with any gnt bit
rnd_data  out  8  value for the granted requester; valid when rnd_valid=1
ready  out  1  1 when FSM in SERVE
seed_zero_err  out  1  sticky; set when a zero seed was loaded

Behaviour:
- CA step, s = current state, n = next state: n7=s6; n6=s7^s5; n5=s6^s5^s4; n4=s5^s3; n3=s4^s3^s2; n2=s3^s1; n1=s2^s1^s0; n0=s1. The state changes only on a step; otherwise it holds.
- Reset (reset=0 at posedge):
  - state=DEFAULT_SEED, FSM=WARMUP, warm_cnt=WARMUP, rr_ptr=0.
  - gnt=0, rnd_valid=0, rnd_data=0, ready=0, seed_zero_err=0.
  - If WARMUP=0, FSM=SERVE instead.
- FSM states: WARMUP, SERVE, PAUSE.
- WARMUP:
  - Each cycle: one CA step, warm_cnt decrements.
  - When warm_cnt==1 at the edge, FSM moves to SERVE.
  - No grants; req is ignored, not queued.
- SERVE:
  - gen_enable=0 moves FSM to PAUSE with no grant that cycle.
  - Otherwise, if any req bit is set, pick winner = first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Next edge: gnt[winner]=1, rnd_valid=1, rnd_data=current state, one CA step, rr_ptr=(winner+1) mod NUM_REQ.
  - No request: gnt=0, rnd_valid=0, rnd_data holds its last value, state holds.
- PAUSE:
  - No grants; state holds.
  - gen_enable=1 returns FSM to SERVE on the next edge, with grants possible from the cycle after that.
- Latency: req sampled at edge k produces gnt/rnd_valid at edge k+1.
  - A requester that holds req high is granted again whenever it wins.
  - Back-to-back grants to different requesters are allowed every cycle.
- seed_load=1 at any edge, in any state, has highest priority:
  - state=seed_value, or 8'h01 with seed_zero_err set to 1 if seed_value==0.
  - warm_cnt=WARMUP, FSM=WARMUP (or SERVE if WARMUP=0), gnt=0, rnd_valid=0.
  - rr_ptr is unchanged.
- seed_zero_err clears only on reset.
- ready=1 exactly while FSM=SERVE; it is registered with the FSM.
- Reset asserted mid-grant clears gnt/rnd_valid on that edge. No partial state survives.

Test Plan:
1. Reset with defaults, req=0 -> ready=0 for 4 cycles, then ready=1. The first grant with req=4'b0001 gives rnd_data=8'h13. The next grant gives 8'h2D.
2. seed_load with seed_value=8'h00 -> seed_zero_err=1, state becomes 8'h01. After warm-up, the first value is 8'h13 and the flag stays set.
3. req=4'b1111 held for 8 SERVE cycles, rr_ptr=0 -> grants 0,1,2,3,0,1,2,3 on consecutive cycles. rnd_data follows the CA sequence, one step per grant.
4. req=4'b1010 with rr_ptr=2 -> grant 3, then 1, then 3. Requesters 0 and 2 are never granted.
5. seed_load=1 in the same cycle as req=4'b0001 in SERVE -> no gnt next cycle, ready=0, and the warm-up restarts from the new seed.
6. gen_enable=0 for 3 cycles with req=4'b0100 -> no gnt and state held. After gen_enable=1, gnt[2] arrives 2 cycles later with the value held from before the pause.

Source files
------------

// File: rtl/ca_rng_scheduler.sv
// ca_rng_scheduler
//   Shares an 8-bit hybrid rule-90/150 cellular-automaton generator among
//   NUM_REQ requesters using round-robin arbitration. Each grant returns the
//   current CA value and advances the CA by one step. The block also handles
//   seeding: a zero seed is replaced by 8'h01 and flagged. After reset or a
//   seed load, the CA runs WARMUP steps before any request is served.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous active-low reset
//   seed_load      pulse: load seed_value and restart warm-up
//   seed_value     seed to load
//   gen_enable     1 = grants allowed while serving
//   req            per-requester request level
//   gnt            registered one-hot grant, one cycle wide
//   rnd_valid      high together with any gnt bit
//   rnd_data       CA value for the granted requester
//   ready          1 while the FSM is in SERVE
//   seed_zero_err  sticky flag: a zero seed was loaded (cleared by reset only)
//
// State  | meaning
// -------+-----------------------------------------------------------
// WARMUP | CA steps every cycle, warm count runs down, no grants
// SERVE  | arbitrate requests, one grant and one CA step per winner
// PAUSE  | gen_enable low: no grants, CA holds

module ca_rng_scheduler #(
   parameter int         NUM_REQ      = 4,
   parameter int         WARMUP       = 4,
   parameter logic [7:0] DEFAULT_SEED = 8'h01
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               seed_load,
   input  logic [7:0]         seed_value,
   input  logic               gen_enable,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               rnd_valid,
   output logic [7:0]         rnd_data,
   output logic               ready,
   output logic               seed_zero_err
);

   localparam int PW = $clog2(NUM_REQ);

   localparam logic [1:0] ST_WARMUP = 2'd0;
   localparam logic [1:0] ST_SERVE  = 2'd1;
   localparam logic [1:0] ST_PAUSE  = 2'd2;

   // With WARMUP=0 the block serves straight out of reset or seed load.
   localparam logic [1:0] ST_START  = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;
   localparam logic       START_RDY = (WARMUP == 0);
   localparam logic [7:0] WARM_INIT = 8'(WARMUP);

   logic [7:0]         r_ca;
   logic [1:0]         r_fsm;
   logic [7:0]         r_warm_cnt;
   logic [PW-1:0]      r_rr_ptr;
   logic [NUM_REQ-1:0] r_gnt;
   logic               r_rnd_valid;
   logic [7:0]         r_rnd_data;
   logic               r_ready;
   logic               r_seed_zero_err;

   logic [7:0]         w_ca_step;
   logic               w_hi_found;
   logic [PW-1:0]      w_hi_win;
   logic               w_any_req;
   logic [PW-1:0]      w_lo_win;
   logic [PW-1:0]      w_winner;
   logic [PW-1:0]      w_ptr_nxt;

   // Cells 5, 3 and 1 are rule 150 (include self), the rest are rule 90;
   // the neighbours beyond both ends are fixed at zero.
   always_comb begin
      w_ca_step[7] = r_ca[6];
      w_ca_step[6] = r_ca[7] ^ r_ca[5];
      w_ca_step[5] = r_ca[6] ^ r_ca[5] ^ r_ca[4];
      w_ca_step[4] = r_ca[5] ^ r_ca[3];
      w_ca_step[3] = r_ca[4] ^ r_ca[3] ^ r_ca[2];
      w_ca_step[2] = r_ca[3] ^ r_ca[1];
      w_ca_step[1] = r_ca[2] ^ r_ca[1] ^ r_ca[0];
      w_ca_step[0] = r_ca[1];
   end

   // Round robin: the lowest set bit at or above the pointer wins.
   // Otherwise the search wraps to the lowest set bit overall.
   // The loops run downward so that the last hit is the lowest index.
   always_comb begin
      w_hi_found = 1'b0;
      w_hi_win   = '0;
      w_any_req  = 1'b0;
      w_lo_win   = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req[j]) begin
            w_any_req = 1'b1;
            w_lo_win  = PW'(j);
            if (PW'(j) >= r_rr_ptr) begin
               w_hi_found = 1'b1;
               w_hi_win   = PW'(j);
            end
         end
      end
      w_winner  = w_hi_found ? w_hi_win : w_lo_win;
      w_ptr_nxt = (w_winner == PW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_ca            <= DEFAULT_SEED;
         r_fsm           <= ST_START;
         r_warm_cnt      <= WARM_INIT;
         r_rr_ptr        <= '0;
         r_gnt           <= '0;
         r_rnd_valid     <= 1'b0;
         r_rnd_data      <= 8'h00;
         r_ready         <= START_RDY;
         r_seed_zero_err <= 1'b0;
      end else if (seed_load) begin
         // The all-zero state is a fixed point of the CA, so it is never loaded.
         if (seed_value == 8'h00) begin
            r_ca            <= 8'h01;
            r_seed_zero_err <= 1'b1;
         end else begin
            r_ca <= seed_value;
         end
         r_fsm       <= ST_START;
         r_warm_cnt  <= WARM_INIT;
         r_gnt       <= '0;
         r_rnd_valid <= 1'b0;
         r_ready     <= START_RDY;
      end else begin
         r_gnt       <= '0;
         r_rnd_valid <= 1'b0;
         case (r_fsm)
            ST_WARMUP: begin
               r_ca       <= w_ca_step;
               r_warm_cnt <= r_warm_cnt - 8'd1;
               if (r_warm_cnt <= 8'd1) begin
                  r_fsm   <= ST_SERVE;
                  r_ready <= 1'b1;
               end
            end
            ST_SERVE: begin
               if (!gen_enable) begin
                  r_fsm   <= ST_PAUSE;
                  r_ready <= 1'b0;
               end else if (w_any_req) begin
                  r_gnt       <= NUM_REQ'(1) << w_winner;
                  r_rnd_valid <= 1'b1;
                  r_rnd_data  <= r_ca;
                  r_ca        <= w_ca_step;
                  r_rr_ptr    <= w_ptr_nxt;
               end
            end
            ST_PAUSE: begin
               if (gen_enable) begin
                  r_fsm   <= ST_SERVE;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_fsm      <= ST_START;
               r_warm_cnt <= WARM_INIT;
               r_ready    <= START_RDY;
            end
         endcase
      end
   end

   assign gnt           = r_gnt;
   assign rnd_valid     = r_rnd_valid;
   assign rnd_data      = r_rnd_data;
   assign ready         = r_ready;
   assign seed_zero_err = r_seed_zero_err;

endmodule

// File: tb/tb_ca_rng_scheduler.sv
// tb_ca_rng_scheduler
//   Drives ca_rng_scheduler through the directed scenarios first and then a
//   randomized run. The reference model works from the CA rule
//   (shift-left ^ shift-right ^ rule-150 cells) and from a modulo search
//   for the next requester.

module tb_ca_rng_scheduler;

   localparam int         N      = 4;
   localparam int         WARM   = 4;
   localparam logic [7:0] DSEED  = 8'h01;
   localparam logic [7:0] R150   = 8'h2A;

   localparam int M_WARM  = 0;
   localparam int M_SERVE = 1;
   localparam int M_PAUSE = 2;

   logic         clock = 1'b0;
   logic         reset;
   logic         seed_load;
   logic [7:0]   seed_value;
   logic         gen_enable;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic         rnd_valid;
   logic [7:0]   rnd_data;
   logic         ready;
   logic         seed_zero_err;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0]   m_ca;
   int           m_mode;
   int           m_cnt;
   int           m_ptr;
   logic [N-1:0] exp_gnt;
   logic         exp_valid;
   logic [7:0]   exp_data;
   logic         exp_ready;
   logic         exp_err;

   ca_rng_scheduler #(
      .NUM_REQ      (N),
      .WARMUP       (WARM),
      .DEFAULT_SEED (DSEED)
   ) u_dut (
      .clock         (clock),
      .reset         (reset),
      .seed_load     (seed_load),
      .seed_value    (seed_value),
      .gen_enable    (gen_enable),
      .req           (req),
      .gnt           (gnt),
      .rnd_valid     (rnd_valid),
      .rnd_data      (rnd_data),
      .ready         (ready),
      .seed_zero_err (seed_zero_err)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ca_next(input logic [7:0] s);
      return (s << 1) ^ (s >> 1) ^ (s & R150);
   endfunction

   task automatic model_edge(input logic rst_n, input logic sl, input logic [7:0] sv,
                             input logic ge, input logic [N-1:0] rq);
      bit done;
      int idx;
      exp_gnt   = '0;
      exp_valid = 1'b0;
      if (!rst_n) begin
         m_ca     = DSEED;
         m_cnt    = WARM;
         m_mode   = (WARM == 0) ? M_SERVE : M_WARM;
         m_ptr    = 0;
         exp_data = 8'h00;
         exp_err  = 1'b0;
      end else if (sl) begin
         if (sv == 8'h00) begin
            m_ca    = 8'h01;
            exp_err = 1'b1;
         end else begin
            m_ca = sv;
         end
         m_cnt  = WARM;
         m_mode = (WARM == 0) ? M_SERVE : M_WARM;
      end else if (m_mode == M_WARM) begin
         m_ca  = ca_next(m_ca);
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) m_mode = M_SERVE;
      end else if (m_mode == M_SERVE) begin
         if (!ge) begin
            m_mode = M_PAUSE;
         end else begin
            done = 1'b0;
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr + k) % N;
               if (!done && rq[idx]) begin
                  done        = 1'b1;
                  exp_gnt     = '0;
                  exp_gnt[idx] = 1'b1;
                  exp_valid   = 1'b1;
                  exp_data    = m_ca;
                  m_ca        = ca_next(m_ca);
                  m_ptr       = (idx + 1) % N;
               end
            end
         end
      end else begin
         if (ge) m_mode = M_SERVE;
      end
      exp_ready = (m_mode == M_SERVE);
   endtask

   // Apply one set of inputs across one rising edge, then compare all outputs
   // with the model on the following falling edge.
   task automatic cyc(input logic rst_n, input logic sl, input logic [7:0] sv,
                      input logic ge, input logic [N-1:0] rq);
      reset      = rst_n;
      seed_load  = sl;
      seed_value = sv;
      gen_enable = ge;
      req        = rq;
      model_edge(rst_n, sl, sv, ge, rq);
      @(posedge clock);
      @(negedge clock);
      check_val("gnt", 32'(gnt), 32'(exp_gnt));
      check_val("rnd_valid", 32'(rnd_valid), 32'(exp_valid));
      check_val("rnd_data", 32'(rnd_data), 32'(exp_data));
      check_val("ready", 32'(ready), 32'(exp_ready));
      check_val("seed_zero_err", 32'(seed_zero_err), 32'(exp_err));
   endtask

   initial begin
      logic [N-1:0] exp_seq [8];
      logic [N-1:0] r_req;
      logic [7:0]   r_seed;

      // Reset, then four warm-up cycles with ready low.
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 4'b0000);
      check_val("tp1_rst_ready", 32'(ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 8'h00, 1'b1, 4'b0000);
         check_val("tp1_warm_ready", 32'(ready), 32'd0);
      end
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 4'b0000);
      check_val("tp1_ready_up", 32'(ready), 32'd1);

      // All four requesting with the pointer at 0: rotate 0,1,2,3,0,1,2,3.
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, 8'h00, 1'b1, 4'b1111);
         check_val("tp3_rr_gnt", 32'(gnt), 32'(exp_seq[i]));
         if (i == 0) check_val("tp1_first_data", 32'(rnd_data), 32'h13);
         if (i == 1) check_val("tp1_second_data", 32'(rnd_data), 32'h2D);
      end

      // Move the pointer to 2, then alternate between requesters 3 and 1.
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 4'b0010);
      check_val("tp4_setup", 32'(gnt), 32'h2);
      exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b1000;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 8'h00, 1'b1, 4'b1010);
         check_val("tp4_gnt", 32'(gnt), 32'(exp_seq[i]));
      end

      // A seed load beats a request in the same cycle and restarts warm-up.
      cyc(1'b1, 1'b1, 8'hA5, 1'b1, 4'b0001);
      check_val("tp5_no_gnt", 32'(gnt), 32'd0);
      check_val("tp5_ready", 32'(ready), 32'd0);
      for (int i = 0; i < WARM; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 4'b0001);
      check_val("tp5_ready_back", 32'(ready), 32'd1);

      // A zero seed is replaced by 01 and sets the sticky flag.
      cyc(1'b1, 1'b1, 8'h00, 1'b1, 4'b0000);
      check_val("tp2_err", 32'(seed_zero_err), 32'd1);
      for (int i = 0; i < WARM; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 4'b0000);
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 4'b0001);
      check_val("tp2_data", 32'(rnd_data), 32'h13);
      check_val("tp2_err_sticky", 32'(seed_zero_err), 32'd1);

      // Pause for three cycles, then resume. The grant comes two edges later
      // and carries the value that was held across the pause.
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 8'h00, 1'b0, 4'b0100);
         check_val("tp6_pause_gnt", 32'(gnt), 32'd0);
      end
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 4'b0100);
      check_val("tp6_resume_gnt", 32'(gnt), 32'd0);
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 4'b0100);
      check_val("tp6_gnt", 32'(gnt), 32'h4);
      check_val("tp6_data", 32'(rnd_data), 32'h2D);

      // Randomized traffic with occasional pauses, seed loads and resets.
      for (int i = 0; i < 3000; i++) begin
         r_req  = N'($urandom_range(0, (1 << N) - 1));
         r_seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         cyc(($urandom_range(0, 299) != 0),
             ($urandom_range(0, 39) == 0),
             r_seed,
             ($urandom_range(0, 7) != 0),
             r_req);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
